// File: rtl/y_update_accum_cplx.sv
// Complex diagonal Y-update accumulator: seed with y_diag, then add/sub a counted stream of terms.
// Optional saturating arithmetic and sat_flag output are enabled by defining Y_ACCUM_SAT_EN.
module y_update_accum_cplx #(
  parameter int unsigned W     = 24,
  parameter int unsigned CNT_W = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [CNT_W-1:0]   num_terms,
  input  logic [2*W-1:0]     y_diag,
  input  logic               term_valid,
  input  logic [2*W-1:0]     term_in,
  input  logic               term_sub,
  output logic               busy,
  output logic [2*W-1:0]     y_out,
  output logic               y_valid,
`ifdef Y_ACCUM_SAT_EN
  output logic               sat_flag,
`endif
  output logic               drop_err
);

  localparam int unsigned CW = 2 * W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [W-1:0]     acc_re, acc_im, acc_re_next, acc_im_next;
  logic [CNT_W-1:0] cnt, cnt_next, cnt_inc;
  logic [CNT_W-1:0] n_lat, n_lat_next;
  logic             r_valid, r_sub;
  logic [CW-1:0]    r_term;
  logic [W-1:0]     res_re, res_im;

`ifdef Y_ACCUM_SAT_EN
  localparam logic [W-1:0] SAT_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] SAT_MIN = {1'b1, {(W-1){1'b0}}};

  logic sat_re, sat_im;
  logic sat_any, sat_any_next;

  // Returns {saturated, value}; one guard bit exposes signed overflow.
  function automatic logic [W:0] add_sub(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic sub);
    logic [W:0] s;
    s = sub ? ({a[W-1], a} - {b[W-1], b}) : ({a[W-1], a} + {b[W-1], b});
    if (s[W] != s[W-1]) begin
      return {1'b1, (s[W] ? SAT_MIN : SAT_MAX)};
    end
    return {1'b0, s[W-1:0]};
  endfunction
`else
  // Plain two's-complement wraparound per component.
  function automatic logic [W-1:0] add_sub(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic sub);
    return sub ? (a - b) : (a + b);
  endfunction
`endif

  // Component-wise arithmetic on the registered term.
  always_comb begin
`ifdef Y_ACCUM_SAT_EN
    {sat_re, res_re} = add_sub(acc_re, r_term[CW-1:W], r_sub);
    {sat_im, res_im} = add_sub(acc_im, r_term[W-1:0], r_sub);
`else
    res_re = add_sub(acc_re, r_term[CW-1:W], r_sub);
    res_im = add_sub(acc_im, r_term[W-1:0], r_sub);
`endif
  end

  assign cnt_inc = cnt + CNT_W'(1);

  // Next-state and datapath update.
  always_comb begin
    state_next  = state;
    acc_re_next = acc_re;
    acc_im_next = acc_im;
    cnt_next    = cnt;
    n_lat_next  = n_lat;
`ifdef Y_ACCUM_SAT_EN
    sat_any_next = sat_any;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          acc_re_next = y_diag[CW-1:W];
          acc_im_next = y_diag[W-1:0];
          cnt_next    = '0;
          n_lat_next  = num_terms;
`ifdef Y_ACCUM_SAT_EN
          sat_any_next = 1'b0;
`endif
          state_next  = (num_terms == '0) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (r_valid) begin
          acc_re_next = res_re;
          acc_im_next = res_im;
          cnt_next    = cnt_inc;
`ifdef Y_ACCUM_SAT_EN
          sat_any_next = sat_any | sat_re | sat_im;
`endif
          if (cnt_inc == n_lat) begin
            state_next = DONE;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Input stage, datapath registers and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_valid  <= 1'b0;
      r_term   <= '0;
      r_sub    <= 1'b0;
      acc_re   <= '0;
      acc_im   <= '0;
      cnt      <= '0;
      n_lat    <= '0;
      busy     <= 1'b0;
      y_out    <= '0;
      y_valid  <= 1'b0;
      drop_err <= 1'b0;
`ifdef Y_ACCUM_SAT_EN
      sat_any  <= 1'b0;
      sat_flag <= 1'b0;
`endif
    end else begin
      r_valid <= term_valid;
      r_term  <= term_in;
      r_sub   <= term_sub;
      acc_re  <= acc_re_next;
      acc_im  <= acc_im_next;
      cnt     <= cnt_next;
      n_lat   <= n_lat_next;
      busy    <= (state_next != IDLE);
      y_valid <= (state == DONE);
      if (state == DONE) begin
        y_out <= {acc_re, acc_im};
      end
      // Terms arriving when no update is accumulating are discarded.
      if (r_valid && (state != ACCUM)) begin
        drop_err <= 1'b1;
      end
`ifdef Y_ACCUM_SAT_EN
      sat_any <= sat_any_next;
      if (state == IDLE && start) begin
        sat_flag <= 1'b0;
      end else if (state == DONE) begin
        sat_flag <= sat_any;
      end
`endif
    end
  end

endmodule

// File: tb/tb_y_update_accum_cplx.sv
// Directed self-checking bench for y_update_accum_cplx (W=24, CNT_W=8).
module tb_y_update_accum_cplx;

  localparam int unsigned W  = 24;
  localparam int unsigned CW = 48;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic [7:0]    num_terms;
  logic [CW-1:0] y_diag;
  logic          term_valid;
  logic [CW-1:0] term_in;
  logic          term_sub;
  logic          busy;
  logic [CW-1:0] y_out;
  logic          y_valid;
  logic          drop_err;
`ifdef Y_ACCUM_SAT_EN
  logic          sat_flag;
`endif

  int checks   = 0;
  int failures = 0;

  y_update_accum_cplx #(.W(W), .CNT_W(8)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .num_terms  (num_terms),
    .y_diag     (y_diag),
    .term_valid (term_valid),
    .term_in    (term_in),
    .term_sub   (term_sub),
    .busy       (busy),
    .y_out      (y_out),
    .y_valid    (y_valid),
`ifdef Y_ACCUM_SAT_EN
    .sat_flag   (sat_flag),
`endif
    .drop_err   (drop_err)
  );

  always #5 clock = ~clock;

  function automatic logic [CW-1:0] cx(input int re, input int im);
    return {24'(re), 24'(im)};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Bounded wait for the y_valid pulse; a timeout is a failed comparison.
  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (y_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check(tag, 48'(y_valid), 48'd1);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; num_terms = '0; y_diag = '0;
    term_valid = 1'b0; term_in = '0; term_sub = 1'b0;
    tick(); tick();
    reset = 1'b0;
    check("rst_y_out", y_out, '0);
    check("rst_y_valid", 48'(y_valid), 48'd0);
    check("rst_busy", 48'(busy), 48'd0);
    check("rst_drop_err", 48'(drop_err), 48'd0);

    // Basic accumulate: {100,-50} + {10,5} - {30,-20} + {1,1} = {81,-24}
    start = 1'b1; num_terms = 8'd3; y_diag = cx(100, -50);
    term_valid = 1'b1; term_in = cx(10, 5); term_sub = 1'b0;
    tick();
    start = 1'b0;
    check("basic_busy", 48'(busy), 48'd1);
    term_in = cx(30, -20); term_sub = 1'b1;
    tick();
    term_in = cx(1, 1); term_sub = 1'b0;
    tick();
    term_valid = 1'b0;
    tick();
    check("basic_done_busy", 48'(busy), 48'd1);
    check("basic_no_early_valid", 48'(y_valid), 48'd0);
    tick();
    check("basic_y_valid", 48'(y_valid), 48'd1);
    check("basic_y_out", y_out, cx(81, -24));
    check("basic_busy_low", 48'(busy), 48'd0);
    tick();
    check("basic_pulse_one", 48'(y_valid), 48'd0);
    check("basic_hold", y_out, cx(81, -24));

    // Zero terms: y_valid on the 2nd cycle after start
    start = 1'b1; num_terms = 8'd0; y_diag = cx(7, -7);
    tick();
    start = 1'b0;
    check("zero_busy", 48'(busy), 48'd1);
    check("zero_no_valid", 48'(y_valid), 48'd0);
    tick();
    check("zero_y_valid", 48'(y_valid), 48'd1);
    check("zero_y_out", y_out, cx(7, -7));
    check("zero_drop", 48'(drop_err), 48'd0);
    tick();

    // Gapped stream with ignored starts while busy
    start = 1'b1; num_terms = 8'd2; y_diag = cx(1000, 2000);
    tick();
    term_valid = 1'b1; term_in = cx(5, 6); term_sub = 1'b0;
    start = 1'b1; num_terms = 8'd9; y_diag = cx(-1, -1);
    tick();
    term_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      start = (i % 2 == 0);
      tick();
    end
    start = 1'b0;
    check("gap_busy", 48'(busy), 48'd1);
    check("gap_no_valid", 48'(y_valid), 48'd0);
    term_valid = 1'b1; term_in = cx(-5, 10); term_sub = 1'b1;
    tick();
    term_valid = 1'b0;
    wait_valid("gap_valid");
    check("gap_y_out", y_out, cx(1010, 1996));
    tick();

    // Overflow of the real part
    start = 1'b1; num_terms = 8'd1; y_diag = cx(32'h7FFFFF, 0);
    term_valid = 1'b1; term_in = cx(1, 0); term_sub = 1'b0;
    tick();
    start = 1'b0; term_valid = 1'b0;
    wait_valid("ovf_valid");
`ifdef Y_ACCUM_SAT_EN
    check("ovf_y_out_sat", y_out, cx(32'h7FFFFF, 0));
    check("ovf_sat_flag", 48'(sat_flag), 48'd1);
`else
    check("ovf_y_out_wrap", y_out, cx(32'h800000, 0));
`endif
    tick();

    // Drop error: term while IDLE, then a normal update
    term_valid = 1'b1; term_in = cx(99, 99);
    tick();
    term_valid = 1'b0;
    tick();
    check("drop_set", 48'(drop_err), 48'd1);
    start = 1'b1; num_terms = 8'd1; y_diag = cx(-100, 50);
    term_valid = 1'b1; term_in = cx(20, -30); term_sub = 1'b1;
    tick();
    start = 1'b0; term_valid = 1'b0;
    wait_valid("drop_next_valid");
    check("drop_next_y_out", y_out, cx(-120, 80));
    check("drop_sticky", 48'(drop_err), 48'd1);
`ifdef Y_ACCUM_SAT_EN
    check("sat_flag_clear", 48'(sat_flag), 48'd0);
`endif
    tick();

    // Reset mid-update after 1 of 4 terms
    start = 1'b1; num_terms = 8'd4; y_diag = cx(3, 3);
    term_valid = 1'b1; term_in = cx(1, 1); term_sub = 1'b0;
    tick();
    start = 1'b0; term_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_y_out", y_out, '0);
    check("mid_rst_busy", 48'(busy), 48'd0);
    check("mid_rst_y_valid", 48'(y_valid), 48'd0);
    check("mid_rst_drop", 48'(drop_err), 48'd0);
    tick(); tick(); tick();
    check("mid_rst_no_valid", 48'(y_valid), 48'd0);

    // Fresh update, then a back-to-back zero-term update
    start = 1'b1; num_terms = 8'd2; y_diag = cx(-8, 9);
    term_valid = 1'b1; term_in = cx(2, 3); term_sub = 1'b0;
    tick();
    start = 1'b0;
    term_in = cx(4, 5); term_sub = 1'b1;
    tick();
    term_valid = 1'b0;
    tick();
    tick();
    check("fresh_y_valid", 48'(y_valid), 48'd1);
    check("fresh_y_out", y_out, cx(-10, 7));
    start = 1'b1; num_terms = 8'd0; y_diag = cx(11, -12);
    tick();
    start = 1'b0;
    check("b2b_pulse_one", 48'(y_valid), 48'd0);
    tick();
    check("b2b_y_valid", 48'(y_valid), 48'd1);
    check("b2b_y_out", y_out, cx(11, -12));
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
